// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Config nibble layout per source: {level, fall, rise, enable}.
package vic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } vic_state_t;

    localparam int CFG_EN   = 0;
    localparam int CFG_RISE = 1;
    localparam int CFG_FALL = 2;
    localparam int CFG_LVL  = 3;

endpackage

// File: rtl/vic_irq_ctrl_if.sv
// CPU-side request/acknowledge/end-of-interrupt handshake of the VIC.
// master = interrupt controller, slave = CPU interrupt entry logic.
interface vic_irq_ctrl_if #(
    parameter int N_SRC = 31,
    localparam int AW   = $clog2(N_SRC)
);
    logic          irq;
    logic [AW-1:0] irq_addr;
    logic          pending;
    logic          ack;
    logic          eoi;

    modport master (output irq, output irq_addr, output pending, input ack, input eoi);
    modport slave  (input irq, input irq_addr, input pending, output ack, output eoi);
endinterface

// File: rtl/vic_src_cell.sv
// One interrupt source: optional input synchronizer (VIC_SYNC_EN), edge
// detection against the previous sample, and the pending bit.
module vic_src_cell
    import vic_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ext,
    input  logic [3:0] i_cfg,
    input  logic       i_clr,
    output logic       o_pend
);

    logic w_s;

`ifdef VIC_SYNC_EN
    logic r_sync1, r_sync2;

    // Reset to the live line so a line held high across reset is not an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= i_ext;
            r_sync2 <= i_ext;
        end else begin
            r_sync1 <= i_ext;
            r_sync2 <= r_sync1;
        end
    end
    assign w_s = r_sync2;
`else
    assign w_s = i_ext;
`endif

    logic r_prev;
    logic r_pend;
    logic w_rise, w_fall, w_evt, w_edge_mode;

    always_ff @(posedge i_clk) r_prev <= w_s;

    assign w_rise      = w_s & ~r_prev;
    assign w_fall      = ~w_s & r_prev;
    assign w_edge_mode = i_cfg[CFG_RISE] | i_cfg[CFG_FALL];
    assign w_evt       = (i_cfg[CFG_RISE] & w_rise) | (i_cfg[CFG_FALL] & w_fall);

    // A new event beats an acknowledge clear landing in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)                 r_pend <= 1'b0;
        else if (!i_cfg[CFG_EN])   r_pend <= 1'b0;
        else if (!w_edge_mode)     r_pend <= (w_s == i_cfg[CFG_LVL]);
        else if (w_evt)            r_pend <= 1'b1;
        else if (i_clr)            r_pend <= 1'b0;
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/vic_irq_ctrl.sv
// Vectored interrupt controller top: source cells, fixed lowest-index-wins
// priority, IDLE/REQ/SERVICE handshake FSM. Option macro: VIC_SYNC_EN.
module vic_irq_ctrl
    import vic_pkg::*;
#(
    parameter int N_SRC = 31,
    localparam int AW   = $clog2(N_SRC)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_SRC-1:0]   i_ext,
    input  logic [4*N_SRC-1:0] i_reg,
    input  logic               i_en,
    vic_irq_ctrl_if.master     cpu
);

    vic_state_t       r_state, w_state_nxt;
    logic [AW-1:0]    r_addr;
    logic             r_opend;
    logic [N_SRC-1:0] w_pend;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_mask;
    logic [AW-1:0]    w_win;
    logic             w_any;
    logic             w_ack_take;

    assign w_ack_take = (r_state == REQ) && cpu.ack;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_clr[gi] = w_ack_take && (r_addr == AW'(gi));

        vic_src_cell u_cell (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_ext  (i_ext[gi]),
            .i_cfg  (i_reg[4*gi +: 4]),
            .i_clr  (w_clr[gi]),
            .o_pend (w_pend[gi])
        );
    end

    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_pend[i]) w_win = AW'(i);
        end
    end
    assign w_any = |w_pend;

    // An ack in the same cycle that i_en falls still completes the handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en && w_any) w_state_nxt = REQ;
            REQ: begin
                if (cpu.ack)   w_state_nxt = SERVICE;
                else if (!i_en) w_state_nxt = IDLE;
            end
            SERVICE: if (cpu.eoi) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // While presenting, the presented source is not "another" pending one.
    assign w_mask = (r_state == REQ) ? (N_SRC'(1) << r_addr) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_opend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_state_nxt == REQ) r_addr <= w_win;
            r_opend <= |(w_pend & ~w_mask);
        end
    end

    assign cpu.irq      = (r_state == REQ);
    assign cpu.irq_addr = r_addr;
    assign cpu.pending  = r_opend;

endmodule
